// File: rtl/alu_pkg.sv
// Opcode encoding and legality check shared by the ALU pipeline.
// ALU_SHIFT_EN enables the SLL/SRL/SRA opcodes (3/4/5).
package alu_pkg;
    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_SRA = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
`ifdef ALU_SHIFT_EN
            OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/alu_pipe_if.sv
// Handshake/operand/result bundle between decode, alu_pipe and writeback.
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ALU_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
    logic             err;
    logic [CNT_W-1:0] done_cnt;

    modport slave (
        input  in_valid, src1, src2, ALU_control, out_ready,
        output in_ready, out_valid, result, zero, cout, overflow, err, done_cnt
    );
    modport master (
        output in_valid, src1, src2, ALU_control, out_ready,
        input  in_ready, out_valid, result, zero, cout, overflow, err, done_cnt
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath between the S1 and S2 registers.
// ALU_SHIFT_EN adds the shift opcodes; otherwise they report err.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_src1,
    input  logic [WIDTH-1:0] i_src2,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_cout,
    output logic             o_overflow,
    output logic             o_err
);
`ifdef ALU_SHIFT_EN
    localparam int SH_W = $clog2(WIDTH);
`endif

    logic [WIDTH:0] w_add;
    logic [WIDTH:0] w_sub;
    logic           w_add_ovf;
    logic           w_sub_ovf;
    logic           w_legal;

    assign w_add     = {1'b0, i_src1} + {1'b0, i_src2};
    assign w_sub     = {1'b0, i_src1} + {1'b0, ~i_src2} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add_ovf = (i_src1[WIDTH-1] == i_src2[WIDTH-1]) && (w_add[WIDTH-1] != i_src1[WIDTH-1]);
    assign w_sub_ovf = (i_src1[WIDTH-1] != i_src2[WIDTH-1]) && (w_sub[WIDTH-1] != i_src1[WIDTH-1]);
    assign w_legal   = op_legal(i_op);

    always_comb begin
        o_result   = '0;
        o_cout     = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            OP_AND: o_result = i_src1 & i_src2;
            OP_OR:  o_result = i_src1 | i_src2;
            OP_NOR: o_result = ~(i_src1 | i_src2);
            OP_ADD: begin
                o_result   = w_add[WIDTH-1:0];
                o_cout     = w_add[WIDTH];
                o_overflow = w_add_ovf;
            end
            OP_SUB: begin
                o_result   = w_sub[WIDTH-1:0];
                o_cout     = w_sub[WIDTH];
                o_overflow = w_sub_ovf;
            end
            // sign of the true difference is the raw sign corrected by overflow
            OP_SLT: o_result = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
`ifdef ALU_SHIFT_EN
            OP_SLL: o_result = i_src1 << i_src2[SH_W-1:0];
            OP_SRL: o_result = i_src1 >> i_src2[SH_W-1:0];
            OP_SRA: o_result = $signed(i_src1) >>> i_src2[SH_W-1:0];
`endif
            default: o_result = '0;
        endcase
    end

    assign o_err  = !w_legal;
    assign o_zero = w_legal && (o_result == '0);
endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with saturating completion counter.
// Build with ALU_SHIFT_EN to enable the shift opcodes in alu_core.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int STAGES = 2;

    logic [STAGES:1]  r_vld_pipe;
    logic [WIDTH-1:0] r_src1;
    logic [WIDTH-1:0] r_src2;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_cout;
    logic             r_ovf;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_cout;
    logic             w_ovf;
    logic             w_err;

    // a stage may load when empty or when its content moves on this edge
    assign w_s2_adv   = !r_vld_pipe[2] || bus.out_ready;
    assign w_s1_adv   = !r_vld_pipe[1] || w_s2_adv;
    assign w_out_fire = r_vld_pipe[2] && bus.out_ready;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .i_src1    (r_src1),
        .i_src2    (r_src2),
        .i_op      (r_op),
        .o_result  (w_res),
        .o_zero    (w_zero),
        .o_cout    (w_cout),
        .o_overflow(w_ovf),
        .o_err     (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_op       <= '0;
            r_res      <= '0;
            r_zero     <= 1'b0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_vld_pipe[1] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_src1 <= bus.src1;
                    r_src2 <= bus.src2;
                    r_op   <= bus.ALU_control;
                end
            end
            if (w_s2_adv) begin
                r_vld_pipe[2] <= r_vld_pipe[1];
                if (r_vld_pipe[1]) begin
                    r_res  <= w_res;
                    r_zero <= w_zero;
                    r_cout <= w_cout;
                    r_ovf  <= w_ovf;
                    r_err  <= w_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_out_fire && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign bus.in_ready  = w_s1_adv;
    assign bus.out_valid = r_vld_pipe[2];
    assign bus.result    = r_res;
    assign bus.zero      = r_zero;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;
    assign bus.err       = r_err;
    assign bus.done_cnt  = r_cnt;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: queue-based reference model plus literal vectors.
// Honours ALU_SHIFT_EN the same way the design does.
module tb_alu_pipe;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CMAX = 15;

    typedef struct {
        logic [W-1:0] r;
        logic z, c, v, e;
        int   acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] rdy_pat;
    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int mcnt   = 0;
    exp_t q[$];
    logic [W-1:0] log_q[$];
    logic prev_stall = 1'b0;
    logic [W+3:0] prev_o, cur_o;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus();
    alu_pipe #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
        longint sa, sb, s;
        longint hi, lo;
        hi = (longint'(1) << 31) - 1;
        lo = -(longint'(1) << 31);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m.r = '0; m.z = 0; m.c = 0; m.v = 0; m.e = 0; m.acc = 0;
        case (op)
            4'd0:  m.r = a & b;
            4'd1:  m.r = a | b;
            4'd12: m.r = ~(a | b);
            4'd2: begin
                s = sa + sb;
                m.r = a + b;
                m.c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                m.v = (s > hi) || (s < lo);
            end
            4'd6: begin
                s = sa - sb;
                m.r = a - b;
                m.c = (a >= b);
                m.v = (s > hi) || (s < lo);
            end
            4'd7: m.r = (sa < sb) ? 1 : 0;
`ifdef ALU_SHIFT_EN
            4'd3: m.r = a << b[4:0];
            4'd4: m.r = a >> b[4:0];
            4'd5: m.r = 32'(sa >>> b[4:0]);
`endif
            default: m.e = 1'b1;
        endcase
        m.z = !m.e && (m.r == '0);
        return m;
    endfunction

    always @(posedge clk) edges <= edges + 1;

    // out_ready follows a rotating pattern, updated just after each edge
    initial begin
        bus.out_ready = 1'b1;
        rdy_pat = 16'hFFFF;
        forever begin
            @(posedge clk); #2;
            bus.out_ready = rdy_pat[0];
            rdy_pat = {rdy_pat[0], rdy_pat[15:1]};
        end
    end

    // single compare process: samples mid-cycle what the next edge will see
    always @(negedge clk) begin
        exp_t m;
        logic exp_ov;
        cur_o = {bus.result, bus.zero, bus.cout, bus.overflow, bus.err};
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
            prev_stall = 1'b0;
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_done_cnt", bus.done_cnt, 0);
            chk("rst_outputs", cur_o, 0);
        end else begin
            exp_ov = (q.size() > 0) && (q[0].acc <= edges - 1);
            chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
            chk("out_valid", bus.out_valid, exp_ov);
            if (bus.out_valid && q.size() > 0)
                chk("beat", cur_o, {q[0].r, q[0].z, q[0].c, q[0].v, q[0].e});
            if (prev_stall)
                chk("hold", cur_o, prev_o);
            chk("done_cnt", bus.done_cnt, mcnt);
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                log_q.push_back(bus.result);
                void'(q.pop_front());
                if (mcnt < CMAX) mcnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                m = model(bus.ALU_control, bus.src1, bus.src2);
                m.acc = edges + 1;
                q.push_back(m);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_o = cur_o;
        end
    end

    // drives a beat at edge+1 and returns at edge+1 after the accepting edge
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        logic acc;
        n = 0;
        bus.in_valid = 1'b1; bus.ALU_control = op; bus.src1 = a; bus.src2 = b;
        do begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout got=not_accepted want=accepted op=%0d", op);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got=%0d pending want=0", q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [2:0] zcv, input logic ee);
        send(op, a, b);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat1"}, bus.out_valid, 0);
        @(negedge clk);
        chk({nm, "_lat2"}, bus.out_valid, 1);
        chk(nm, {bus.result, bus.zero, bus.cout, bus.overflow, bus.err}, {er, zcv, ee});
        @(posedge clk); #1;
    endtask

    logic [3:0] ops [20] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd2, 4'd6, 4'd7, 4'd3,
                             4'd4, 4'd5, 4'd9, 4'd15, 4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};

    initial begin
        logic [W-1:0] a, b;
        bus.in_valid = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.ALU_control = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // stall: out_ready low for three cycles while four beats arrive
        rdy_pat = 16'hFFF8;
        send(4'd2, 32'd1, 32'd1);
        send(4'd2, 32'd2, 32'd2);
        #2;
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_out_valid", bus.out_valid, 1);
        send(4'd2, 32'd3, 32'd3);
        send(4'd2, 32'd4, 32'd4);
        bus.in_valid = 1'b0;
        drain();
        chk("stall_done_cnt", bus.done_cnt, 4);
        chk("stall_order0", log_q[0], 32'd2);
        chk("stall_order1", log_q[1], 32'd4);
        chk("stall_order2", log_q[2], 32'd6);
        chk("stall_order3", log_q[3], 32'd8);

        rdy_pat = 16'hFFFF;
        lit("add_ovf",  4'd2,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 3'b001, 1'b0);
        lit("add_wrap", 4'd2,  32'hFFFF_FFFF, 32'h1, 32'h0,         3'b110, 1'b0);
        lit("sub_eq",   4'd6,  32'd5, 32'd5,         32'h0,         3'b110, 1'b0);
        lit("slt_neg",  4'd7,  32'hFFFF_FFFF, 32'h1, 32'h1,         3'b000, 1'b0);
        lit("slt_ovf",  4'd7,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 3'b000, 1'b0);
        lit("slt_f",    4'd7,  32'h1, 32'hFFFF_FFFF, 32'h0,         3'b100, 1'b0);
        lit("illegal9", 4'd9,  32'h1234, 32'h5678,   32'h0,         3'b000, 1'b1);
`ifdef ALU_SHIFT_EN
        lit("op3",      4'd3,  32'h1, 32'h4,         32'h10,        3'b000, 1'b0);
`else
        lit("op3",      4'd3,  32'h1, 32'h4,         32'h0,         3'b000, 1'b1);
`endif
        lit("sub_brw",  4'd6,  32'd3, 32'd5,         32'hFFFF_FFFE, 3'b000, 1'b0);
        lit("sub_ovf",  4'd6,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 3'b011, 1'b0);
        lit("nor0",     4'd12, 32'h0, 32'h0,         32'hFFFF_FFFF, 3'b000, 1'b0);
        lit("and",      4'd0,  32'hF0F0, 32'hFF00,   32'hF000,      3'b000, 1'b0);

        // reset with both stages occupied
        rdy_pat = 16'h0000;
        @(posedge clk); #1;
        send(4'd2, 32'd10, 32'd20);
        send(4'd6, 32'd30, 32'd7);
        #2;
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_out_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_now_out_valid", bus.out_valid, 0);
        chk("rst_now_done_cnt", bus.done_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_pat = 16'hFFFF;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_beat", bus.out_valid, 0);
        end
        @(posedge clk); #1;

        // mixed stream with irregular backpressure; counter must saturate
        rdy_pat = 16'b1011_0110_1101_1011;
        for (int i = 0; i < 20; i++) begin
            a = (32'h8000_0000 >> i) ^ (32'h0F0F_1234 * i);
            b = (i % 3 == 0) ? 32'(i) : (32'hFFFF_FFFF - 32'(i * 977));
            send(ops[i], a, b);
        end
        bus.in_valid = 1'b0;
        rdy_pat = 16'hFFFF;
        drain();
        chk("sat_done_cnt", bus.done_cnt, CMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the single-cycle combinational ALU. It keeps the existing opcode encoding and the zero/carry/overflow flag semantics, and generalises the operand width. It adds a valid/ready handshake with full-throughput backpressure, illegal-opcode reporting and a saturating completion counter. It sits between the decode stage and writeback, and is exercised by the pattern-driven self-checking bench.

## Interface
- WIDTH, 32, operand/result width (≥4, power of two).
- CNT_W, 16, width of completion counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- src1  in  WIDTH  operand A.
- src2  in  WIDTH  operand B.
- ALU_control  in  4  opcode.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- cout  out  1  carry out of MSB (ADD/SUB only).
- overflow  out  1  signed overflow (ADD/SUB only).
- err  out  1  beat carried an illegal opcode.
- done_cnt  out  CNT_W  completed output handshakes, saturating.

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR; all other codes are illegal (see Configuration for 3/4/5).
- ADD: {cout,result} = src1+src2; overflow = operands same sign, result sign differs.
- SUB: computed as src1 + ~src2 + 1; cout = carry out (1 = no borrow, src1 ≥ src2 unsigned); overflow = operand signs differ, result sign ≠ src1 sign.
- SLT: result = ($signed(src1) < $signed(src2)) ? 1 : 0, computed overflow-correct; cout = overflow = 0.
- AND/OR/NOR: bitwise; cout = overflow = 0.
- zero = (result == 0) for every legal op.
- Illegal opcode: result = 0, zero = cout = overflow = 0, err = 1; beat still flows and counts.
- done_cnt increments on each out_valid && out_ready; holds at 2^CNT_W−1.

## Timing
- Two register stages: S1 captures operands/opcode; S2 captures computed result and flags.
- Beat accepted at edge N (in_valid && in_ready) → out_valid high after edge N+1; latency 2 edges.
- Throughput one beat/cycle while out_ready = 1.
- s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational, no in_valid dependency).
- out_valid held with result/flags stable until out_ready; outputs never change while out_valid && !out_ready.
- Stall: two beats buffered max; in_ready low when both stages full and out_ready low.
- Simultaneous accept and output handshake in the same cycle is legal; order is strictly preserved.
- Reset (async assert, any time incl. mid-operation): s1_valid = s2_valid = 0, out_valid = 0, result = 0, zero/cout/overflow/err = 0, done_cnt = 0; in-flight beats discarded. in_ready = 1 from the first cycle after deassert.

## Configuration
- ALU_SHIFT_EN defined: opcodes 3 SLL, 4 SRL, 5 SRA, shift amount src2[$clog2(WIDTH)−1:0], src1 is shifted; cout = overflow = 0; zero per rule.
- ALU_SHIFT_EN undefined: opcodes 3/4/5 are illegal (err = 1, result 0).

## Structure
- Package alu_pkg: opcode localparams (OP_AND … OP_NOR, OP_SLL/SRL/SRA), legality function.
- Sub-module alu_core: purely combinational WIDTH-parametrised datapath (result, zero, cout, overflow, err) between S1 and S2; alu_pipe owns handshake, stage registers and counter.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, zcv 001, out_valid two edges after accept.
- ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, zcv 110; SUB 5 − 5 → 0x00000000, zcv 110.
- SLT 0xFFFFFFFF vs 0x00000001 → 0x00000001, zcv 000; SLT 0x80000000 vs 0x7FFFFFFF → 1 (overflow-safe).
- Back-to-back 4 beats, out_ready low for 3 cycles → in_ready drops after 2 accepted, results emerge in order and stable while stalled, done_cnt = 4.
- Opcode 9 → result 0, zcv 000, err 1; opcode 3 with src1 = 1, src2 = 4 → 0x10 if ALU_SHIFT_EN else err 1.
- rst_n asserted with both stages full → out_valid/done_cnt 0 immediately, no stale beat after release.
